// File: rtl/mem_access_pkg.sv
// Shared memory-op codes, FSM state encoding and lane helpers for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MemOpNone = 4'd0,
        MemOpLdB  = 4'd1,
        MemOpLdH  = 4'd2,
        MemOpLdW  = 4'd3,
        MemOpLdBu = 4'd4,
        MemOpLdHu = 4'd5,
        MemOpStB  = 4'd6,
        MemOpStH  = 4'd7,
        MemOpStW  = 4'd8,
        MemOpLlW  = 4'd9,
        MemOpScW  = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StResp  = 2'd2,
        StDrain = 2'd3
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MemOpLdB) && (op <= MemOpScW);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return ((op >= MemOpLdB) && (op <= MemOpLdHu)) || (op == MemOpLlW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return ((op >= MemOpStB) && (op <= MemOpStW)) || (op == MemOpScW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            MemOpLdH, MemOpLdHu, MemOpStH:           return lo[0];
            MemOpLdW, MemOpStW, MemOpLlW, MemOpScW:  return |lo;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            MemOpStB: return 4'b0001 << lo;
            MemOpStH: return lo[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] data);
        case (op)
            MemOpStB: return {4{data[7:0]}};
            MemOpStH: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  op,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        unique case (addr_lo)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            MemOpLdB:  load_data = {{24{lane_b[7]}}, lane_b};
            MemOpLdBu: load_data = {24'd0, lane_b};
            MemOpLdH:  load_data = {{16{lane_h[15]}}, lane_h};
            MemOpLdHu: load_data = {16'd0, lane_h};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues data-memory requests over req/ack, aligns loads, stalls the
// pipeline while an access is outstanding and drains requests killed by a flush.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [OP_W-1:0]   ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [31:0]       ex_store_data,
    input  logic [31:0]       ex_inst_pc,
    input  logic [31:0]       ex_instr,
    input  logic              ex_inst_valid,
    input  logic              llbit_cur,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       mem_inst_pc,
    output logic [31:0]       mem_instr,
    output logic              mem_inst_valid,
    output logic              mem_LLbit_we,
    output logic              mem_LLbit_value,
    output logic              excp_ale,
    output logic              stallreq
);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        lo_q, lo_d;

    logic [3:0]  op;
    logic [1:0]  lo;
    logic [31:0] load_data;
    logic        bubble;

    assign op = ex_mem_op[3:0];
    assign lo = ex_mem_addr[1:0];

    mem_load_align u_load_align (
        .rdata     (rdata_q),
        .addr_lo   (lo_q),
        .op        (op_q),
        .load_data (load_data)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        lo_d    = lo_q;

        mem_wd          = ex_wd;
        mem_wreg        = ex_wreg;
        mem_wdata       = ex_wdata;
        mem_LLbit_we    = 1'b0;
        mem_LLbit_value = 1'b0;
        excp_ale        = 1'b0;
        stallreq        = 1'b0;
        bubble          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_mem_op(op) && !flush) begin
                    if (is_misaligned(op, lo)) begin
                        excp_ale  = 1'b1;
                        mem_wreg  = 1'b0;
                        mem_wdata = '0;
                    end else if (op == MemOpScW && !llbit_cur) begin
                        mem_wdata    = '0;
                        mem_LLbit_we = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        bubble   = 1'b1;
                        req_d    = 1'b1;
                        we_d     = is_store_op(op);
                        be_d     = store_be(op, lo);
                        addr_d   = {ex_mem_addr[ADDR_W-1:2], 2'b00};
                        wdata_d  = store_wdata(op, ex_store_data);
                        op_d     = op;
                        lo_d     = lo;
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                stallreq = 1'b1;
                bubble   = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = dmem_rdata;
                    state_d = flush ? StIdle : StResp;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (is_load_op(op_q)) begin
                    mem_wdata = load_data;
                    if (op_q == MemOpLlW) begin
                        mem_LLbit_we    = 1'b1;
                        mem_LLbit_value = 1'b1;
                    end
                end else if (op_q == MemOpScW) begin
                    mem_wdata    = 32'd1;
                    mem_LLbit_we = 1'b1;
                end else begin
                    mem_wreg  = 1'b0;
                    mem_wdata = '0;
                end
            end
            StDrain: begin
                // The bus cannot cancel a request, so wait it out before issuing anew.
                stallreq = 1'b1;
                bubble   = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bubble || flush || rst) begin
            mem_wd          = '0;
            mem_wreg        = 1'b0;
            mem_wdata       = '0;
            mem_LLbit_we    = 1'b0;
            mem_LLbit_value = 1'b0;
            excp_ale        = 1'b0;
        end
        if (rst) begin
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    assign mem_inst_pc    = ex_inst_pc;
    assign mem_instr      = ex_instr;
    assign mem_inst_valid = ex_inst_valid;

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access: a transaction-level model predicts each op's result and
// stall schedule; one negedge process compares DUT outputs against it every cycle.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_inst_pc;
    logic [31:0] ex_instr;
    logic        ex_inst_valid;
    logic        llbit_cur;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_inst_pc;
    logic [31:0] mem_instr;
    logic        mem_inst_valid;
    logic        mem_LLbit_we;
    logic        mem_LLbit_value;
    logic        excp_ale;
    logic        stallreq;

    always #5 clk = ~clk;

    mem_access #(.OP_W(4), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_wd           (ex_wd),
        .ex_wreg         (ex_wreg),
        .ex_wdata        (ex_wdata),
        .ex_mem_op       (ex_mem_op),
        .ex_mem_addr     (ex_mem_addr),
        .ex_store_data   (ex_store_data),
        .ex_inst_pc      (ex_inst_pc),
        .ex_instr        (ex_instr),
        .ex_inst_valid   (ex_inst_valid),
        .llbit_cur       (llbit_cur),
        .flush           (flush),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_be         (dmem_be),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_inst_pc     (mem_inst_pc),
        .mem_instr       (mem_instr),
        .mem_inst_valid  (mem_inst_valid),
        .mem_LLbit_we    (mem_LLbit_we),
        .mem_LLbit_value (mem_LLbit_value),
        .excp_ale        (excp_ale),
        .stallreq        (stallreq)
    );

    typedef struct packed {
        logic        issue;
        logic        ale;
        logic        dc;      // wd/wdata are don't-care (no register write)
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        llwe;
        logic        llval;
        logic        we;
        logic [3:0]  be;
        logic [31:0] pwdata;
    } res_t;

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle expectations written by the driver, consumed at negedge.
    bit          chk_en = 1'b0;
    bit          exp_req, exp_stall, exp_pay, exp_mode;
    res_t        exp_res;
    logic [31:0] exp_paddr;

    logic [31:0] snap_wdata, snap_pwdata;
    logic [3:0]  snap_be;
    logic        snap_wreg, snap_llwe, snap_llval, snap_ale, snap_we;
    int          stall_cnt, req_cnt, wreg_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input int op, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata,
                                   input bit llbit, input logic [4:0] wd, input bit wreg,
                                   input logic [31:0] alu);
        res_t r;
        int lo, size, v;
        logic [31:0] sh;
        r = '0;
        r.wd = wd;
        r.wreg = wreg;
        r.wdata = alu;
        if (op < 1 || op > 10) return r;
        lo = int'(addr[1:0]);
        if (op == 1 || op == 4 || op == 6) size = 1;
        else if (op == 2 || op == 5 || op == 7) size = 2;
        else size = 4;
        if (lo % size != 0) begin
            r.ale = 1'b1; r.wreg = 1'b0; r.dc = 1'b1;
            return r;
        end
        if (op == 10 && !llbit) begin
            r.wdata = 32'd0; r.llwe = 1'b1;
            return r;
        end
        r.issue = 1'b1;
        sh = rdata >> (8 * lo);
        case (op)
            1: begin v = int'(sh & 32'hFF); if (v >= 128) v -= 256; r.wdata = 32'(v); end
            2: begin v = int'(sh & 32'hFFFF); if (v >= 32768) v -= 65536; r.wdata = 32'(v); end
            3: r.wdata = rdata;
            4: r.wdata = sh & 32'hFF;
            5: r.wdata = sh & 32'hFFFF;
            9: begin r.wdata = rdata; r.llwe = 1'b1; r.llval = 1'b1; end
            10: begin r.wdata = 32'd1; r.llwe = 1'b1; end
            default: begin r.wreg = 1'b0; r.dc = 1'b1; end
        endcase
        if ((op >= 6 && op <= 8) || op == 10) begin
            r.we = 1'b1;
            if (size == 1) begin
                r.be = 4'(1 << lo); r.pwdata = sdata[7:0] * 32'h0101_0101;
            end else if (size == 2) begin
                r.be = 4'(3 << lo); r.pwdata = sdata[15:0] * 32'h0001_0001;
            end else begin
                r.be = 4'hF; r.pwdata = sdata;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            check("stallreq", {31'd0, stallreq}, {31'd0, exp_stall});
            check("inst_pc", mem_inst_pc, ex_inst_pc);
            check("instr", mem_instr, ex_instr);
            check("inst_valid", {31'd0, mem_inst_valid}, {31'd0, ex_inst_valid});
            if (stallreq) stall_cnt++;
            if (dmem_req) req_cnt++;
            if (mem_wreg) wreg_cnt++;
            if (exp_pay) begin
                check("dmem_addr", dmem_addr, exp_paddr);
                check("dmem_we", {31'd0, dmem_we}, {31'd0, exp_res.we});
                if (exp_res.we) begin
                    check("dmem_be", {28'd0, dmem_be}, {28'd0, exp_res.be});
                    check("dmem_wdata", dmem_wdata, exp_res.pwdata);
                end
                snap_be = dmem_be; snap_pwdata = dmem_wdata; snap_we = dmem_we;
            end
            if (!exp_mode) begin
                check("bubble wd", {27'd0, mem_wd}, 32'd0);
                check("bubble wreg", {31'd0, mem_wreg}, 32'd0);
                check("bubble wdata", mem_wdata, 32'd0);
                check("bubble llwe", {31'd0, mem_LLbit_we}, 32'd0);
                check("bubble ale", {31'd0, excp_ale}, 32'd0);
            end else begin
                check("res wreg", {31'd0, mem_wreg}, {31'd0, exp_res.wreg});
                check("res llwe", {31'd0, mem_LLbit_we}, {31'd0, exp_res.llwe});
                if (exp_res.llwe)
                    check("res llval", {31'd0, mem_LLbit_value}, {31'd0, exp_res.llval});
                check("res ale", {31'd0, excp_ale}, {31'd0, exp_res.ale});
                if (!exp_res.dc) begin
                    check("res wd", {27'd0, mem_wd}, {27'd0, exp_res.wd});
                    check("res wdata", mem_wdata, exp_res.wdata);
                end
                snap_wdata = mem_wdata; snap_wreg = mem_wreg; snap_ale = excp_ale;
                snap_llwe = mem_LLbit_we; snap_llval = mem_LLbit_value;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage. waits = WAIT cycles (ack in the last one);
    // fl_at = WAIT cycle index to flush in, or waits+1 to flush the response cycle.
    task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input bit llbit, input int waits,
                         input bit wreg, input bit fl_idle, input int fl_at);
        res_t m;
        bit flushed;
        stall_cnt = 0; req_cnt = 0; wreg_cnt = 0;
        snap_wdata = 'x; snap_pwdata = 'x; snap_be = 'x;
        snap_wreg = 'x; snap_llwe = 'x; snap_llval = 'x; snap_ale = 'x; snap_we = 'x;
        ex_wd = 5'($urandom); ex_wreg = wreg; ex_wdata = $urandom;
        ex_mem_op = 4'(op); ex_mem_addr = addr; ex_store_data = sdata;
        ex_inst_pc = $urandom; ex_instr = $urandom; ex_inst_valid = 1'($urandom);
        llbit_cur = llbit; flush = fl_idle; dmem_ack = 1'b0; dmem_rdata = $urandom;
        m = model(op, addr, sdata, rdata, llbit, ex_wd, wreg, ex_wdata);
        exp_res = m; exp_req = 1'b0; exp_pay = 1'b0; exp_paddr = addr & ~32'h3;
        if (fl_idle || !m.issue) begin
            exp_stall = 1'b0; exp_mode = !fl_idle;
            step();
            flush = 1'b0;
            return;
        end
        exp_stall = 1'b1; exp_mode = 1'b0;
        step();
        flushed = 1'b0;
        for (int w = 1; w <= waits; w++) begin
            exp_req = 1'b1; exp_pay = 1'b1;
            dmem_ack = (w == waits);
            dmem_rdata = (w == waits) ? rdata : $urandom;
            flush = (w == fl_at);
            if (flush) flushed = 1'b1;
            step();
            flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        exp_req = 1'b0; exp_pay = 1'b0;
        if (!flushed) begin
            exp_stall = 1'b0;
            flush = (fl_at == waits + 1);
            exp_mode = !flush;
            step();
            flush = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_mem_op = '0; ex_mem_addr = '0;
        ex_store_data = '0; ex_inst_pc = '0; ex_instr = '0; ex_inst_valid = 1'b0;
        llbit_cur = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_pay = 1'b0; exp_mode = 1'b0;
        exp_res = '0; exp_paddr = '0;
        chk_en = 1'b1;
        #1;
        check("reset dmem_req", {31'd0, dmem_req}, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset dmem_be", {28'd0, dmem_be}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(1, 32'h1003, 32'h0, 32'h80FF_1234, 1'b0, 1, 1'b1, 1'b0, 0);
        check("ldb wdata", snap_wdata, 32'hFFFF_FF80);
        check("ldb wreg", {31'd0, snap_wreg}, 32'd1);
        check("ldb stall cycles", stall_cnt, 2);

        do_op(7, 32'h2002, 32'h0000_BEEF, 32'h0, 1'b0, 2, 1'b1, 1'b0, 0);
        check("sth be", {28'd0, snap_be}, 32'b1100);
        check("sth wdata", snap_pwdata, 32'hBEEF_BEEF);
        check("sth we", {31'd0, snap_we}, 32'd1);
        check("sth wreg", {31'd0, snap_wreg}, 32'd0);

        do_op(3, 32'h3000, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b1, 1'b0, 0);
        check("ldw stall cycles", stall_cnt, 4);
        check("ldw req cycles", req_cnt, 3);
        check("ldw wdata", snap_wdata, 32'h1234_5678);

        do_op(10, 32'h4000, 32'h55, 32'h0, 1'b0, 1, 1'b1, 1'b0, 0);
        check("scfail req cycles", req_cnt, 0);
        check("scfail wdata", snap_wdata, 32'd0);
        check("scfail llwe", {31'd0, snap_llwe}, 32'd1);
        check("scfail llval", {31'd0, snap_llval}, 32'd0);

        do_op(9, 32'h4000, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b1, 1'b0, 0);
        check("llw wdata", snap_wdata, 32'hCAFE_F00D);
        check("llw llwe", {31'd0, snap_llwe}, 32'd1);
        check("llw llval", {31'd0, snap_llval}, 32'd1);

        do_op(10, 32'h4000, 32'h55, 32'h0, 1'b1, 1, 1'b1, 1'b0, 0);
        check("scok req cycles", req_cnt, 1);
        check("scok wdata", snap_wdata, 32'd1);
        check("scok be", {28'd0, snap_be}, 32'hF);
        check("scok llval", {31'd0, snap_llval}, 32'd0);

        do_op(3, 32'h1002, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 0);
        check("ale flag", {31'd0, snap_ale}, 32'd1);
        check("ale wreg", {31'd0, snap_wreg}, 32'd0);
        check("ale req cycles", req_cnt, 0);

        do_op(3, 32'h5000, 32'h0, 32'hFFFF_FFFF, 1'b0, 4, 1'b1, 1'b0, 2);
        check("drain stall cycles", stall_cnt, 5);
        check("drain req cycles", req_cnt, 4);
        check("drain no write", wreg_cnt, 0);

        // Reset while a load is waiting on the bus.
        ex_mem_op = 4'd3; ex_mem_addr = 32'h6000; flush = 1'b0; dmem_ack = 1'b0;
        exp_res = model(3, 32'h6000, ex_store_data, 32'h0, 1'b0, ex_wd, ex_wreg, ex_wdata);
        exp_req = 1'b0; exp_pay = 1'b0; exp_stall = 1'b1; exp_mode = 1'b0;
        exp_paddr = 32'h6000;
        step();
        exp_req = 1'b1; exp_pay = 1'b1;
        step();
        rst = 1'b1;
        exp_req = 1'b0; exp_pay = 1'b0; exp_stall = 1'b0;
        #1;
        check("rst mid-wait dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst mid-wait stallreq", {31'd0, stallreq}, 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 250; i++) begin
            int op, waits, fl_at;
            logic [31:0] a;
            bit fi;
            op = $urandom_range(0, 15);
            a = $urandom;
            waits = $urandom_range(1, 4);
            fi = ($urandom_range(0, 9) == 0);
            fl_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, waits + 1) : 0;
            do_op(op, a, $urandom, $urandom, 1'($urandom_range(0, 1)), waits,
                  1'($urandom_range(0, 1)), fi, fl_at);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
